// File: rtl/song_recorder_if.sv
// rtl/song_recorder_if.sv - sequential read port between the song recorder and a playback engine
interface song_recorder_if #(
  parameter int LEN_BITS = 12
);
  logic                rd_start;
  logic                rd_next;
  logic                rd_valid;
  logic [2:0]          rd_note;
  logic [1:0]          rd_oct;
  logic [LEN_BITS-1:0] rd_len;
  logic                rd_last;

  // Playback engine side: requests entries, consumes the presented fields.
  modport master (
    output rd_start, rd_next,
    input  rd_valid, rd_note, rd_oct, rd_len, rd_last
  );

  // Recorder side: serves the presented entry.
  modport slave (
    input  rd_start, rd_next,
    output rd_valid, rd_note, rd_oct, rd_len, rd_last
  );
endinterface

// File: rtl/song_recorder.sv
// rtl/song_recorder.sv - records key activity as (note, octave, length) entries and replays them
module song_recorder #(
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 100000,
  parameter int LEN_BITS = 12,
  parameter int MIN_LEN  = 20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic [6:0]             note_key_i,
  input  logic [1:0]             octave_i,
  song_recorder_if.slave         rd,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   recording_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]       TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]       DEPTH_C   = CW'(DEPTH);
  localparam logic [LEN_BITS-1:0] MIN_L     = LEN_BITS'(MIN_LEN);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_NOTE, S_REST, S_FULL} state_t;

  state_t              state_q, state_d;
  logic [6:0]          key_q;
  logic [1:0]          oct_s_q, oct_q;
  logic [2:0]          dec_q, dec_d;
  logic [PW-1:0]       presc_q;
  logic                tick;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [2:0]          seg_note_q, seg_note_d;
  logic [1:0]          seg_oct_q, seg_oct_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic                commit;
  logic                change;

  logic [2:0]          mem_note_q [DEPTH];
  logic [1:0]          mem_oct_q  [DEPTH];
  logic [LEN_BITS-1:0] mem_len_q  [DEPTH];

  logic                rd_valid_q, rd_last_q;
  logic [2:0]          rd_note_q;
  logic [1:0]          rd_oct_q;
  logic [LEN_BITS-1:0] rd_len_q;

  assign tick = (presc_q == TICK_LAST);

  // Key decode: rest for no key, 1-based index for a single key, hold on chords.
  always_comb begin
    dec_d = dec_q;
    if (key_q == 7'd0) begin
      dec_d = 3'd0;
    end else if ((key_q & (key_q - 7'd1)) == 7'd0) begin
      for (int i = 0; i < 7; i++) begin
        if (key_q[i]) dec_d = 3'(i + 1);
      end
    end
  end

  // Input registers and the free-running length prescaler.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q   <= '0;
      oct_s_q <= '0;
      oct_q   <= '0;
      dec_q   <= '0;
      presc_q <= '0;
    end else begin
      key_q   <= note_key_i;
      oct_s_q <= octave_i;
      oct_q   <= oct_s_q;
      dec_q   <= dec_d;
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  // Recording FSM: segment tracking, commit decisions, clear priority.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    seg_note_d = seg_note_q;
    seg_oct_d  = seg_oct_q;
    len_d      = len_q;
    commit     = 1'b0;
    change     = (dec_q != seg_note_q) || (oct_q != seg_oct_q);
    if (tick && (len_q != '1)) len_d = len_q + LEN_BITS'(1);
    case (state_q)
      S_IDLE: if (en_i) state_d = S_WAIT;
      S_WAIT: begin
        if (!en_i) begin
          state_d = S_IDLE;
        end else if (dec_q != 3'd0) begin
          state_d    = S_NOTE;
          seg_note_d = dec_q;
          seg_oct_d  = oct_q;
          len_d      = '0;
        end
      end
      S_NOTE, S_REST: begin
        if (!en_i) begin
          // A trailing rest is never stored; a trailing note is.
          state_d = S_IDLE;
          commit  = (state_q == S_NOTE) && (len_q >= MIN_L);
        end else if (change) begin
          commit     = (len_q >= MIN_L);
          seg_note_d = dec_q;
          seg_oct_d  = oct_q;
          len_d      = '0;
          state_d    = (dec_q != 3'd0) ? S_NOTE : S_REST;
        end
      end
      S_FULL: state_d = S_FULL;
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      count_d = count_q + CW'(1);
      if (count_d == DEPTH_C) state_d = S_FULL;
    end
    if (clear_i) begin
      commit  = 1'b0;
      count_d = '0;
      len_d   = '0;
      state_d = en_i ? S_WAIT : S_IDLE;
    end
  end

  // Read pointer: rewind wins over advance; advance saturates at count.
  always_comb begin
    ptr_d = ptr_q;
    if (rd.rd_start) begin
      ptr_d = '0;
    end else if (rd.rd_next) begin
      ptr_d = (ptr_q < count_q) ? ptr_q + CW'(1) : count_q;
    end
  end

  // FSM, segment and pointer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      seg_note_q <= '0;
      seg_oct_q  <= '0;
      len_q      <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      seg_note_q <= seg_note_d;
      seg_oct_q  <= seg_oct_d;
      len_q      <= len_d;
      ptr_q      <= ptr_d;
    end
  end

  // Entry buffer; contents are meaningless beyond count so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      mem_note_q[count_q[AW-1:0]] <= seg_note_q;
      mem_oct_q[count_q[AW-1:0]]  <= seg_oct_q;
      mem_len_q[count_q[AW-1:0]]  <= len_q;
    end
  end

  // Registered read outputs, zeroed when no committed entry is presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_note_q  <= '0;
      rd_oct_q   <= '0;
      rd_len_q   <= '0;
    end else begin
      rd_valid_q <= (ptr_q < count_q);
      rd_last_q  <= (ptr_q < count_q) && (ptr_q == count_q - CW'(1));
      rd_note_q  <= (ptr_q < count_q) ? mem_note_q[ptr_q[AW-1:0]] : '0;
      rd_oct_q   <= (ptr_q < count_q) ? mem_oct_q[ptr_q[AW-1:0]]  : '0;
      rd_len_q   <= (ptr_q < count_q) ? mem_len_q[ptr_q[AW-1:0]]  : '0;
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_last_q;
  assign rd.rd_note  = rd_note_q;
  assign rd.rd_oct   = rd_oct_q;
  assign rd.rd_len   = rd_len_q;
  assign count_o     = count_q;
  assign full_o      = (count_q == DEPTH_C);
  assign recording_o = (state_q == S_NOTE) || (state_q == S_REST);
endmodule

// File: tb/tb_song_recorder.sv
// tb/tb_song_recorder.sv - directed self-checking bench for song_recorder
module tb_song_recorder;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clear;
  logic [6:0] key;
  logic [1:0] octave;
  logic [2:0] count;
  logic       full;
  logic       recording;
  int         checks = 0;
  int         failures = 0;

  song_recorder_if #(.LEN_BITS(4)) rd_if ();

  song_recorder #(
    .DEPTH(4), .TICK_DIV(10), .LEN_BITS(4), .MIN_LEN(2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .clear_i     (clear),
    .note_key_i  (key),
    .octave_i    (octave),
    .rd          (rd_if),
    .count_o     (count),
    .full_o      (full),
    .recording_o (recording)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play(input logic [6:0] k, input int n);
    key = k;
    step(n);
  endtask

  task automatic stop_take();
    en  = 1'b0;
    key = 7'd0;
    step(8);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
  endtask

  task automatic rd_begin();
    rd_if.rd_start = 1'b1;
    step(1);
    rd_if.rd_start = 1'b0;
    step(1);
  endtask

  task automatic rd_adv();
    rd_if.rd_next = 1'b1;
    step(1);
    rd_if.rd_next = 1'b0;
    step(1);
  endtask

  task automatic chk_entry(input string tag, input int nt, input int oc,
                           input int lo, input int hi, input logic last);
    check({tag, "_valid"}, rd_if.rd_valid, 1);
    check({tag, "_note"}, rd_if.rd_note, nt);
    check({tag, "_oct"}, rd_if.rd_oct, oc);
    check({tag, "_len_in_range"}, (int'(rd_if.rd_len) >= lo) && (int'(rd_if.rd_len) <= hi), 1);
    check({tag, "_last"}, rd_if.rd_last, last);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; key = 7'd0; octave = 2'd0;
    rd_if.rd_start = 1'b0; rd_if.rd_next = 1'b0;
    step(3);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_recording", recording, 0);
    check("rst_rd_valid", rd_if.rd_valid, 0);
    check("rst_rd_last", rd_if.rd_last, 0);
    check("rst_rd_note", rd_if.rd_note, 0);
    check("rst_rd_oct", rd_if.rd_oct, 0);
    check("rst_rd_len", rd_if.rd_len, 0);
    rst = 1'b0;
    step(2);

    // Basic take: do 50, rest 30, mi 40 at mid octave.
    octave = 2'd1; en = 1'b1;
    play(7'b0000001, 50);
    play(7'b0000000, 30);
    play(7'b0000100, 40);
    stop_take();
    check("basic_count", count, 3);
    rd_begin();
    chk_entry("basic_e0", 1, 1, 4, 6, 1'b0);
    rd_adv();
    chk_entry("basic_e1", 0, 1, 2, 4, 1'b0);
    rd_adv();
    chk_entry("basic_e2", 3, 1, 3, 5, 1'b1);
    rd_adv();
    check("basic_past_end_valid", rd_if.rd_valid, 0);
    check("basic_past_end_last", rd_if.rd_last, 0);
    rd_if.rd_start = 1'b1; rd_if.rd_next = 1'b1;
    step(1);
    rd_if.rd_start = 1'b0; rd_if.rd_next = 1'b0;
    step(1);
    chk_entry("start_and_next", 1, 1, 4, 6, 1'b0);
    do_clear();
    check("clear_drops_valid", rd_if.rd_valid, 0);
    check("clear_count", count, 0);
    step(4);

    // Glitch reject: a 5-cycle re between two 40-cycle notes.
    en = 1'b1;
    play(7'b0000001, 40);
    play(7'b0000010, 5);
    play(7'b0000100, 40);
    stop_take();
    check("glitch_count", count, 2);
    rd_begin();
    chk_entry("glitch_e0", 1, 1, 3, 5, 1'b0);
    rd_adv();
    chk_entry("glitch_e1", 3, 1, 3, 5, 1'b1);
    do_clear();
    step(4);

    // Chord hold: fa then fa+do keeps fa as a single entry.
    octave = 2'd2; en = 1'b1;
    play(7'b0001000, 30);
    play(7'b0001001, 20);
    stop_take();
    check("chord_count", count, 1);
    rd_begin();
    chk_entry("chord_e0", 4, 2, 4, 6, 1'b1);
    do_clear();
    step(4);

    // Saturation: 300-cycle si saturates the 4-bit length.
    octave = 2'd0; en = 1'b1;
    play(7'b1000000, 300);
    stop_take();
    check("sat_count", count, 1);
    rd_begin();
    chk_entry("sat_e0", 7, 0, 15, 15, 1'b1);
    do_clear();
    step(4);

    // Full: five notes, only four fit.
    octave = 2'd1; en = 1'b1;
    play(7'b0000001, 30);
    play(7'b0000010, 30);
    play(7'b0000100, 30);
    play(7'b0001000, 30);
    play(7'b0010000, 10);
    check("full_count", count, 4);
    check("full_flag", full, 1);
    check("full_recording", recording, 0);
    play(7'b0010000, 20);
    stop_take();
    check("full_count_after_en_off", count, 4);
    check("full_flag_after_en_off", full, 1);
    rd_begin();
    rd_adv();
    rd_adv();
    rd_adv();
    chk_entry("full_e3", 4, 1, 2, 4, 1'b1);
    do_clear();
    check("full_cleared", full, 0);
    step(4);

    // Clear in the same cycle as a commit.
    en = 1'b1;
    play(7'b0000001, 30);
    key = 7'b0000010;
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clrcommit_count", count, 0);
    check("clrcommit_recording", recording, 0);
    step(1);
    check("clrcommit_resumes_from_wait", recording, 1);

    // Reset during recording empties the buffer.
    play(7'b0000010, 30);
    play(7'b0000100, 30);
    check("pre_rst_count", count, 1);
    rst = 1'b1;
    step(1);
    check("midrst_count", count, 0);
    check("midrst_recording", recording, 0);
    rst = 1'b0; en = 1'b0; key = 7'd0;
    rd_begin();
    check("midrst_rd_valid", rd_if.rd_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/song_recorder.md
# song_recorder

Captures what the player performs on the note keys as a sequence of (note, octave, length) entries in an internal buffer, and replays those entries through a sequential read port. It is the writing end of the song-data path: where auto/study playback read a stored song and turn it into LED and buzzer activity, this block turns key activity into a stored song. It sits beside the free-play logic, receives the same one-hot note keys and current octave, and feeds a playback engine through the read port.

## Interface
Parameters:
- DEPTH, 64: buffer entries.
- TICK_DIV, 100000: clk cycles per length tick (1 ms at 100 MHz).
- LEN_BITS, 12: length field width, in ticks.
- MIN_LEN, 20: minimum segment length in ticks. Shorter segments are discarded as glitches.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- en  in  1  recording enable (level).
- clear  in  1  pulse; erase buffer.
- note_key  in  7  one-hot note keys (do..si), level, debounced upstream.
- octave  in  2  current octave: 0 low, 1 mid, 2 high (3 reserved, stored as-is).
- rd_start  in  1  pulse; rewind the read pointer to entry 0 and present it.
- rd_next  in  1  pulse; advance the read pointer and present the next entry.
- rd_valid  out  1  rd_* fields hold a committed entry.
- rd_note  out  3  0 = rest, 1..7 = do..si.
- rd_oct  out  2  stored octave.
- rd_len  out  LEN_BITS  stored length in ticks.
- rd_last  out  1  presented entry is the final committed entry.
- count  out  clog2(DEPTH)+1  committed entries.
- full  out  1  count == DEPTH.
- recording  out  1  state is NOTE or REST.

## Operation
- Key decode: note_key is registered once. All-zero decodes to rest (0). Exactly one bit set decodes to the 1-based index. Multiple bits set hold the previous decoded value, so they cause no change event.
- Tick prescaler: free-running from 0 to TICK_DIV-1; tick pulses on wrap. It is cleared only by rst.
- Segment length counter: cleared at segment start, +1 per tick, saturates at 2^LEN_BITS-1.
- FSM states:
  - IDLE: en=0.
  - WAIT: en=1, no segment open. Rests are ignored. A nonzero key goes to NOTE.
  - NOTE / REST: a segment is open.
  - FULL: count == DEPTH.
- Change event in NOTE/REST: the decoded value or the octave differs from the open segment. On a change event:
  - Commit the open segment if len ≥ MIN_LEN, otherwise discard it.
  - Open a new segment with the new value. Move to NOTE if the value is nonzero, otherwise REST.
- en falling in NOTE: commit the note if len ≥ MIN_LEN, then go to IDLE.
- en falling in REST: the trailing rest is never committed. Go to IDLE.
- en rising from IDLE: go to WAIT. Existing entries are kept, so a new take appends.
- A commit that makes count reach DEPTH sets full and moves the FSM to FULL. FULL ignores keys. The only exits from FULL are clear and rst.
- clear: count ← 0, open segment dropped, state ← WAIT if en else IDLE.
  - clear has priority over a commit in the same cycle.
  - Buffer contents need not be zeroed.
- Read port:
  - rd_start sets ptr=0. rd_next sets ptr=ptr+1, saturating at count.
  - rd_start wins if rd_start and rd_next arrive in the same cycle.
  - rd_valid = (ptr < count). rd_last = rd_valid && ptr == count-1.
  - Reading during recording is allowed and sees only committed entries.
  - If clear makes count ≤ ptr, rd_valid drops.

## Timing
- Reset values: state IDLE, count 0, full 0, recording 0, rd_valid 0, rd_last 0, rd_note/rd_oct/rd_len 0, ptr 0, prescaler 0.
- note_key change at input edge N: decoded at N+1, change detected at N+1, buffer write and count increment visible after edge N+2.
- Read latency: rd_start or rd_next sampled at edge N makes the new entry valid on the outputs after edge N+1. Outputs are registered. A write to the entry being presented updates the outputs on the following cycle.
- Maximum commit rate: one commit per cycle, because a change event needs at least one cycle of new value.
- rst mid-operation: everything returns to reset values in the same edge, and the buffer is considered empty.

## Test plan
Bench uses TICK_DIV=10, MIN_LEN=2, DEPTH=4, LEN_BITS=4.
- Basic take:
  - Stimulus: en=1, octave=1; key 0000001 for 50 cycles, 0 for 30 cycles, 0000100 for 40 cycles, then en=0.
  - Required: count=3 with entries (1,1,5), (0,1,3), (3,1,4), ticks ±1.
- Glitch reject:
  - Stimulus: key 0000010 held 5 cycles between two 40-cycle notes.
  - Required: the glitch is not stored and count=2.
- Multi-key hold and saturation:
  - Stimulus: 0001000 for 30 cycles, then 0001001 for 20 cycles, then 0 with en=0. Separately, one note held 300 cycles.
  - Required: a single entry (4,x,5). The long note is stored with len=15.
- Full:
  - Stimulus: record 5 valid notes.
  - Required: count=4, full=1 after the 4th commit, the 5th note is ignored, recording=0.
- Clear vs commit:
  - Stimulus: clear asserted in the same cycle as a commit.
  - Required: count=0 the next cycle, state WAIT with en=1.
- Read port:
  - Stimulus: after the basic take, rd_start, then 3× rd_next.
  - Required: entries 0..2 presented with rd_last on the 3rd entry, then rd_valid=0. rd_start and rd_next asserted together show entry 0.
